// File: rtl/sd_pkg.sv
// Definitions shared by the SD DAT datapath (writer and reader): CRC16 polynomial,
// write status codes, CRC-status tokens, writer FSM states and a one-bit CRC16 step.
package sd_pkg;

    localparam logic [15:0] CRC16_POLY = 16'h1021;

    localparam logic [1:0] ST_OK  = 2'd0;
    localparam logic [1:0] ST_CRC = 2'd1;
    localparam logic [1:0] ST_WR  = 2'd2;
    localparam logic [1:0] ST_TO  = 2'd3;

    localparam logic [2:0] TOK_OK  = 3'b010;
    localparam logic [2:0] TOK_CRC = 3'b101;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE,
        S_START,
        S_DATA,
        S_CRC,
        S_END,
        S_REL,
        S_STAT,
        S_BUSY,
        S_DONE
    } wr_state_t;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/sd_crc16_line.sv
// Serial CRC16 for one DAT line: clear, accumulate one bit per enable, then shift the
// remainder out MSB first.
module sd_crc16_line
    import sd_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    input  logic shift,
    output logic msb
);

    logic [15:0] crc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= 16'h0000;
        end else if (clr) begin
            crc <= 16'h0000;
        end else if (en) begin
            crc <= crc16_step(crc, bit_in);
        end else if (shift) begin
            crc <= {crc[14:0], 1'b0};
        end
    end

    assign msb = crc[15];

endmodule

// File: rtl/sd_dat_writer.sv
// SD 4-bit DAT write sequencer: frames one block from the byte buffer, appends per-line
// CRC16, then collects the card's CRC-status token and busy on DAT0.
module sd_dat_writer
    import sd_pkg::*;
#(
    parameter int LEN_W   = 10,
    parameter int STAT_TO = 8,
    parameter int BUSY_TO = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start_writing,
    input  logic [LEN_W-1:0] i_buf_len,
    output logic             o_rd_req,
    output logic [LEN_W-1:0] o_rd_addr,
    input  logic [7:0]       i_rd_data,
    output logic [3:0]       o_sd_dat,
    output logic             o_sd_dat_oe,
    input  logic             i_sd_dat0,
    output logic             o_busy,
    output logic             o_done,
    output logic [1:0]       o_status
);

    localparam int DW = LEN_W + 2;

    wr_state_t        state, state_n;
    logic [15:0]      cnt, cnt_n;
    logic [LEN_W:0]   len_r, len_n;
    logic [7:0]       hold, hold_n;
    logic [2:0]       tok, tok_n;
    logic [2:0]       phase, phase_n;
    logic [3:0]       dat_n;
    logic             rd_req_n;
    logic [LEN_W-1:0] addr_n;
    logic [1:0]       status_n;
    logic             crc_en, crc_shift, crc_clr;
    logic [3:0]       crc_msb;
    logic [DW-1:0]    data_last;
    logic [15:0]      fetch_next;
    logic             more_bytes;

    assign data_last  = {len_r, 1'b0} - DW'(1);
    assign fetch_next = {1'b0, cnt[15:1]} + 16'd2;
    assign more_bytes = fetch_next < 16'(len_r);

    // Handshake: a start pulse is taken only in IDLE (o_busy=0); o_busy then stays high
    // through the o_done cycle, and o_status holds its value until the next taken start.
    always_comb begin
        state_n   = state;
        hold_n    = hold;
        tok_n     = tok;
        phase_n   = phase;
        len_n     = len_r;
        status_n  = o_status;
        dat_n     = 4'hF;
        rd_req_n  = 1'b0;
        addr_n    = o_rd_addr;
        crc_en    = 1'b0;
        crc_shift = 1'b0;
        case (state)
            S_IDLE: if (i_start_writing) begin
                state_n  = S_PRE;
                rd_req_n = 1'b1;
                addr_n   = '0;
                status_n = ST_OK;
                len_n    = (i_buf_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, i_buf_len};
            end
            S_PRE: if (cnt == 16'd1) begin
                state_n = S_START;
                dat_n   = 4'h0;
                hold_n  = i_rd_data;
            end
            S_START: begin
                state_n = S_DATA;
                dat_n   = hold[7:4];
                crc_en  = 1'b1;
                if (|len_r[LEN_W:1]) begin
                    rd_req_n = 1'b1;
                    addr_n   = o_rd_addr + LEN_W'(1);
                end
            end
            S_DATA: if (cnt == 16'(data_last)) begin
                state_n   = S_CRC;
                dat_n     = crc_msb;
                crc_shift = 1'b1;
            end else if (!cnt[0]) begin
                dat_n  = hold[3:0];
                crc_en = 1'b1;
            end else begin
                // Next byte arrives now, one cycle after its request in the high-nibble slot.
                dat_n  = i_rd_data[7:4];
                hold_n = i_rd_data;
                crc_en = 1'b1;
                if (more_bytes) begin
                    rd_req_n = 1'b1;
                    addr_n   = o_rd_addr + LEN_W'(1);
                end
            end
            S_CRC: if (cnt == 16'd15) begin
                state_n = S_END;
            end else begin
                dat_n     = crc_msb;
                crc_shift = 1'b1;
            end
            S_END: state_n = S_REL;
            S_REL: if (cnt == 16'd1) begin
                state_n = S_STAT;
                phase_n = 3'd0;
            end
            S_STAT: case (phase)
                3'd0: if (!i_sd_dat0) begin
                    phase_n = 3'd1;
                end else if (cnt == 16'(STAT_TO - 1)) begin
                    state_n  = S_DONE;
                    status_n = ST_TO;
                end
                3'd1, 3'd2, 3'd3: begin
                    tok_n   = {tok[1:0], i_sd_dat0};
                    phase_n = phase + 3'd1;
                end
                default: begin
                    state_n  = S_BUSY;
                    status_n = (tok == TOK_OK) ? ST_OK : (tok == TOK_CRC) ? ST_CRC : ST_WR;
                end
            endcase
            S_BUSY: if (i_sd_dat0) begin
                state_n = S_DONE;
            end else if (cnt == 16'(BUSY_TO - 1)) begin
                state_n  = S_DONE;
                status_n = ST_TO;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        cnt_n = (state_n != state) ? 16'd0 : cnt + 16'd1;
    end

    assign crc_clr = (state_n == S_START);

    for (genvar i = 0; i < 4; i++) begin : g_crc
        sd_crc16_line u_crc (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr    (crc_clr),
            .en     (crc_en),
            .bit_in (dat_n[i]),
            .shift  (crc_shift),
            .msb    (crc_msb[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= 16'd0;
            len_r       <= '0;
            hold        <= 8'h00;
            tok         <= 3'b000;
            phase       <= 3'd0;
            o_sd_dat    <= 4'hF;
            o_sd_dat_oe <= 1'b0;
            o_rd_req    <= 1'b0;
            o_rd_addr   <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_status    <= ST_OK;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            len_r       <= len_n;
            hold        <= hold_n;
            tok         <= tok_n;
            phase       <= phase_n;
            o_sd_dat    <= dat_n;
            o_sd_dat_oe <= (state_n == S_PRE) || (state_n == S_START) || (state_n == S_DATA) ||
                           (state_n == S_CRC) || (state_n == S_END);
            o_rd_req    <= rd_req_n;
            o_rd_addr   <= addr_n;
            o_busy      <= (state_n != S_IDLE);
            o_done      <= (state_n == S_DONE);
            o_status    <= status_n;
        end
    end

endmodule

// File: tb/tb_sd_dat_writer.sv
// Bench for sd_dat_writer: table-driven and random blocks against a frame/CRC model,
// a buffer model with one-cycle read latency, and a card model on DAT0.
module tb_sd_dat_writer;

    localparam int LEN_W   = 10;
    localparam int STAT_TO = 8;
    localparam int BUSY_TO = 200;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_start_writing = 1'b0;
    logic [LEN_W-1:0] i_buf_len = '0;
    logic             o_rd_req;
    logic [LEN_W-1:0] o_rd_addr;
    logic [7:0]       i_rd_data = 8'h00;
    logic [3:0]       o_sd_dat;
    logic             o_sd_dat_oe;
    logic             i_sd_dat0 = 1'b1;
    logic             o_busy;
    logic             o_done;
    logic [1:0]       o_status;

    always #5 clk = ~clk;

    sd_dat_writer #(.LEN_W(LEN_W), .STAT_TO(STAT_TO), .BUSY_TO(BUSY_TO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_start_writing (i_start_writing),
        .i_buf_len       (i_buf_len),
        .o_rd_req        (o_rd_req),
        .o_rd_addr       (o_rd_addr),
        .i_rd_data       (i_rd_data),
        .o_sd_dat        (o_sd_dat),
        .o_sd_dat_oe     (o_sd_dat_oe),
        .i_sd_dat0       (i_sd_dat0),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_status        (o_status)
    );

    // mode: 0 normal card, 1 card never answers, 2 card holds busy forever
    typedef struct {
        int         len;
        int         pat;
        int         gap;
        logic [2:0] tok;
        int         busy_cyc;
        int         mode;
        int         mid_start;
        logic [1:0] exp_status;
    } vec_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] mem [0:1023];
    logic [3:0] exp_q[$];
    logic [3:0] act_q[$];
    logic [LEN_W-1:0] req_q[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] tok_status(input logic [2:0] t);
        if (t == 3'b010) return 2'd0;
        if (t == 3'b101) return 2'd1;
        return 2'd2;
    endfunction

    // CRC as the remainder of (message * x^16) divided by x^16+x^12+x^5+1.
    function automatic logic [15:0] crc_ref(input logic bits[$]);
        logic        q[$];
        logic [16:0] poly;
        logic [15:0] r;
        int          n;
        poly = 17'h11021;
        q = bits;
        n = bits.size();
        repeat (16) q.push_back(1'b0);
        for (int i = 0; i < n; i++)
            if (q[i])
                for (int j = 0; j < 17; j++) q[i+j] = q[i+j] ^ poly[16-j];
        r = 16'h0000;
        for (int j = 0; j < 16; j++) r = {r[14:0], q[n+j]};
        return r;
    endfunction

    task automatic fill_mem(input int pat);
        for (int k = 0; k < 1024; k++) mem[k] = (pat == 1) ? 8'h00 : 8'($urandom);
        if (pat == 2) mem[0] = 8'h80;
    endtask

    task automatic build_frame(input int n_bytes);
        logic [3:0]  nibs[$];
        logic        lb[$];
        logic [15:0] crc [4];
        exp_q.delete();
        for (int k = 0; k < n_bytes; k++) begin
            nibs.push_back(mem[k][7:4]);
            nibs.push_back(mem[k][3:0]);
        end
        for (int i = 0; i < 4; i++) begin
            lb.delete();
            foreach (nibs[m]) lb.push_back(nibs[m][i]);
            crc[i] = crc_ref(lb);
        end
        exp_q.push_back(4'hF);
        exp_q.push_back(4'hF);
        exp_q.push_back(4'h0);
        foreach (nibs[m]) exp_q.push_back(nibs[m]);
        for (int c = 0; c < 16; c++)
            exp_q.push_back({crc[3][15-c], crc[2][15-c], crc[1][15-c], crc[0][15-c]});
        exp_q.push_back(4'hF);
    endtask

    // DAT0 from the card, off = cycles since the DUT released the bus (-1 before that).
    function automatic logic card_bit(input vec_t v, input int off);
        if (off < 0 || v.mode == 1) return 1'b1;
        if (off == v.gap) return 1'b0;
        if (off > v.gap && off <= v.gap + 3) return v.tok[v.gap + 3 - off];
        if (off == v.gap + 4) return 1'b1;
        if (off > v.gap + 4 && (v.mode == 2 || off < v.gap + 5 + v.busy_cyc)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_block(input vec_t v, input string tag);
        int               n_bytes, rel0, done_c, exp_off, mism;
        logic             busy_ok, seen_oe, pend;
        logic [LEN_W-1:0] pend_addr;
        n_bytes = (v.len == 0) ? 1024 : v.len;
        build_frame(n_bytes);
        act_q.delete();
        req_q.delete();
        @(negedge clk);
        check({tag, "_idle_busy"}, o_busy, 0);
        i_buf_len = LEN_W'(v.len);
        i_start_writing = 1'b1;
        i_sd_dat0 = 1'b1;
        @(negedge clk);
        i_start_writing = 1'b0;
        rel0 = -1; done_c = -1; busy_ok = 1'b1; seen_oe = 1'b0; pend = 1'b0; pend_addr = '0;
        for (int c = 0; c < 2 * n_bytes + BUSY_TO + 100; c++) begin
            if (o_sd_dat_oe) begin
                act_q.push_back(o_sd_dat);
                seen_oe = 1'b1;
            end else if (seen_oe && rel0 < 0) begin
                rel0 = c;
            end
            if (!o_busy) busy_ok = 1'b0;
            i_rd_data = pend ? mem[pend_addr] : 8'($urandom);
            pend = o_rd_req;
            pend_addr = o_rd_addr;
            if (o_rd_req) req_q.push_back(o_rd_addr);
            i_start_writing = (c == v.mid_start);
            if (c == v.mid_start) i_buf_len = LEN_W'(3);
            i_sd_dat0 = card_bit(v, (rel0 < 0) ? -1 : c - rel0);
            if (o_done) begin
                done_c = c;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_done_seen"}, (done_c >= 0), 1);
        // A start landing in the DONE cycle must be dropped.
        i_start_writing = 1'b1;
        i_buf_len = LEN_W'(1);
        @(negedge clk);
        i_start_writing = 1'b0;
        i_sd_dat0 = 1'b1;
        check({tag, "_frame_len"}, act_q.size(), exp_q.size());
        mism = 0;
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
            if (act_q[i] != exp_q[i]) mism++;
        check({tag, "_frame_mismatches"}, mism, 0);
        check({tag, "_reads"}, req_q.size(), n_bytes);
        mism = 0;
        foreach (req_q[i]) if (req_q[i] != LEN_W'(i)) mism++;
        check({tag, "_read_addr_mismatches"}, mism, 0);
        check({tag, "_busy_held"}, busy_ok, 1);
        exp_off = (v.mode == 1) ? 2 + STAT_TO :
                  (v.mode == 2) ? v.gap + 5 + BUSY_TO : v.gap + 6 + v.busy_cyc;
        check({tag, "_done_offset"}, done_c - rel0, exp_off);
        check({tag, "_status"}, o_status, v.exp_status);
        check({tag, "_after_busy"}, o_busy, 0);
        check({tag, "_after_done"}, o_done, 0);
        check({tag, "_after_oe"}, o_sd_dat_oe, 0);
    endtask

    vec_t vecs [0:6];
    vec_t rv;

    initial begin
        vecs[0] = '{1, 2, 2, 3'b010, 3, 0, -1, 2'd0};
        vecs[1] = '{8, 1, 3, 3'b101, 2, 0, 10, 2'd1};
        vecs[2] = '{0, 0, 2, 3'b010, 1, 0, -1, 2'd0};
        vecs[3] = '{5, 0, 2, 3'b010, 0, 1, -1, 2'd3};
        vecs[4] = '{3, 0, 4, 3'b010, 0, 2, -1, 2'd3};
        vecs[5] = '{2, 0, 5, 3'b110, 0, 0, -1, 2'd2};
        vecs[6] = '{2, 0, 9, 3'b010, 4, 0, -1, 2'd0};

        repeat (2) @(negedge clk);
        check("reset_dat", o_sd_dat, 4'hF);
        check("reset_oe", o_sd_dat_oe, 0);
        check("reset_rd_req", o_rd_req, 0);
        check("reset_addr", o_rd_addr, 0);
        check("reset_busy", o_busy, 0);
        check("reset_done", o_done, 0);
        check("reset_status", o_status, 0);
        rst_n = 1'b1;

        for (int t = 0; t < 7; t++) begin
            fill_mem(vecs[t].pat);
            run_block(vecs[t], $sformatf("vec%0d", t));
        end

        for (int r = 0; r < 6; r++) begin
            rv.len = $urandom_range(1, 40);
            rv.pat = 0;
            rv.gap = $urandom_range(2, 9);
            rv.tok = 3'($urandom);
            rv.busy_cyc = $urandom_range(0, 10);
            rv.mode = 0;
            rv.mid_start = -1;
            rv.exp_status = tok_status(rv.tok);
            fill_mem(0);
            run_block(rv, $sformatf("rand%0d", r));
        end

        // Asynchronous reset while the CRC is on the bus (cycles 15..30 after start for 6 bytes).
        fill_mem(0);
        @(negedge clk);
        i_buf_len = LEN_W'(6);
        i_start_writing = 1'b1;
        @(negedge clk);
        i_start_writing = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_crc_oe", o_sd_dat_oe, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_crc_oe", o_sd_dat_oe, 0);
        check("rst_crc_dat", o_sd_dat, 4'hF);
        check("rst_crc_busy", o_busy, 0);
        check("rst_crc_rd_req", o_rd_req, 0);
        check("rst_crc_addr", o_rd_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        fill_mem(2);
        run_block(vecs[0], "post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_dat_writer.md
Name: sd_dat_writer

Overview:
Sequencer for the SD 4-bit DAT bus write path: frames one data block from a byte buffer, appends a per-line CRC16, then collects the card's CRC-status token and busy. It sits between the block buffer (byte-wide read port) and the DAT pad drivers, alongside sd_reader on the same DAT lines. It shares the CRC16 polynomial with the rest of the SD datapath.

Parameters:
LEN_W, 10, width of block length and buffer address
STAT_TO, 8, cycles allowed from bus release to the status start bit
BUSY_TO, 65535, cycles allowed for DAT0 busy before timeout

Ports:
clk  in  1  system clock; one DAT bit-time per clk cycle
rst_n  in  1  asynchronous, active-low reset
i_start_writing  in  1  single-cycle start of one block; ignored while o_busy=1
i_buf_len  in  LEN_W  block length in bytes; 0 means 2^LEN_W; sampled on accepted start
o_rd_req  out  1  buffer read strobe
o_rd_addr  out  LEN_W  buffer byte address
i_rd_data  in  8  buffer data, valid exactly 1 cycle after o_rd_req
o_sd_dat  out  4  DAT[3:0] drive value
o_sd_dat_oe  out  1  DAT output enable
i_sd_dat0  in  1  DAT0 input (status token / busy)
o_busy  out  1  block in progress
o_done  out  1  single-cycle completion pulse
o_status  out  2  0=accepted, 1=CRC error token, 2=write error token, 3=timeout; held until next accepted start

Behaviour:
- Reset (async, immediate, any state): state=IDLE, o_sd_dat=4'hF, o_sd_dat_oe=0, o_rd_req=0, o_rd_addr=0, o_busy=0, o_done=0, o_status=0, all four CRCs cleared.
- All outputs registered. o_busy=1 from the cycle after an accepted start until the cycle o_done pulses.
- FSM states: IDLE -> PRE (2 cycles, oe=1, dat=F) -> START (1 cycle, dat=0) -> DATA (2*len cycles) -> CRC (16 cycles) -> END (1 cycle, dat=F) -> REL (2 cycles, oe=0) -> STAT -> BUSY -> DONE (1 cycle, o_done=1) -> IDLE.
- Fetch: byte 0 is requested (o_rd_req=1, addr 0) in the first PRE cycle and captured in the second. Byte k+1 is requested in the high-nibble cycle of byte k and captured into a hold register the next cycle. No request is issued past len-1. o_rd_addr wraps modulo 2^LEN_W.
- DATA: each byte is sent high nibble first; dat[3] carries bit 7/3, dat[0] bit 4/0.
- CRC: four independent CRC16 (x^16+x^12+x^5+1, init 0), one per line, cleared in START.
  - Update per bit: fb=crc[15]^bit; crc={crc[14:0],0}^(fb?16'h1021:0).
  - In CRC state, line i outputs crc_i[15] and shifts left, MSB first.
- STAT: wait for i_sd_dat0=0 (start bit), then sample 3 token bits MSB first, then ignore 1 end bit.
  - Token 010 -> 0; 101 -> 1; any other -> 2.
  - No start bit within STAT_TO cycles of entering STAT -> status 3 and go directly to DONE.
- BUSY: wait until i_sd_dat0=1. If DAT0 is still 0 after BUSY_TO cycles -> status 3.
  - Status tokens 1/2 still pass through BUSY.
- Timeout counter: 16-bit, reset on every state entry.
- i_start_writing during o_busy: dropped, no side effect. Start in the same cycle as DONE: dropped.

Decomposition:
- Shared package sd_pkg holds:
  - CRC16 polynomial constant 16'h1021
  - status codes ST_OK/ST_CRC/ST_WR/ST_TO
  - token constants 3'b010/3'b101
  - FSM state enum
  - a bitwise crc16_step function, reused by sd_reader
- One natural sub-module: sd_crc16_line. It is a serial CRC16 with clear, enable, bit-in, shift-out, and is instantiated 4×.

Test Plan:
- len=1, byte 0x80, DAT0 token 010, busy 3 cycles -> oe high exactly 22 cycles; dat sequence F,F,0,8,0. Line3 CRC is 0x2042 (bits 0010000001000010), lines 0-2 are 0x0000. Then dat=F, o_done pulses, o_status=0.
- len=8, all bytes 0x00, token 101 -> 16 data cycles of 0, all CRC bits 0; o_rd_addr 0..7, each requested once; o_status=1.
- len=0, token 010 -> 1024 bytes read, o_rd_addr wraps from 1023 to 0 only after the block ends; DATA lasts 2048 cycles.
- DAT0 held 1 after REL -> o_status=3 and o_done pulses STAT_TO cycles after STAT entry. DAT0 held 0 in BUSY -> o_status=3 after BUSY_TO cycles.
- i_start_writing pulsed mid-DATA -> ignored, framing unchanged. rst_n low mid-CRC -> oe=0 and dat=F in the same cycle; a new start after release produces a clean block.
